quad_serializer: RTL
====================

QUAD_SERIALIZER -- requirements
Module: quad_serializer

Interface
REQ-001 SHALL have parameter BITS_X, default 10, pixel X coordinate width.
REQ-002 SHALL have parameter BITS_Y, default 9, pixel Y coordinate width.
REQ-003 SHALL have parameter H_ACTIVE, default 640, pixels per line (multiple of 4).
REQ-004 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-005 SHALL have parameter DEPTH, default 4, quad FIFO entries (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port valid_in  input  1  quad present on R/G/B_quad this cycle.
REQ-009 SHALL have ports R_quad, G_quad, B_quad  input  32 each  packed quad; byte [31:24]=lane 0 (x_base+0) … [7:0]=lane 3.
REQ-010 SHALL have port in_ready  output  1  FIFO can accept a quad this cycle.
REQ-011 SHALL have port clr_ovf  input  1  synchronous clear of overflow flag.
REQ-012 SHALL have port overflow  output  1  sticky: a quad was dropped.
REQ-013 SHALL have port pix_valid  output  1  pixel output valid.
REQ-014 SHALL have port pix_ready  input  1  downstream accepts pixel.
REQ-015 SHALL have ports pix_r, pix_g, pix_b  output  8 each  pixel colour.
REQ-016 SHALL have ports pix_x  output  BITS_X, pix_y  output  BITS_Y  pixel coordinates.
REQ-017 SHALL have ports pix_eol, pix_eof  output  1 each  last pixel of line / of frame.

Function
REQ-018 SHALL accept a quad at a rising edge when valid_in=1 and (FIFO not full, or head quad's lane 3 handed off that same edge).
REQ-019 SHALL drop a quad presented with valid_in=1 when not accepted per REQ-018, and set overflow=1 on that edge.
REQ-020 SHALL clear overflow on an edge with clr_ovf=1, except that a drop on the same edge keeps it 1 (set wins).
REQ-021 SHALL drive in_ready = FIFO not full, combinationally from registered occupancy.
REQ-022 SHALL serialize each quad as four pixels in lane order 0,1,2,3 using a 2-bit lane counter.
REQ-023 SHALL register all pix_* outputs; quad accepted at edge N into an empty FIFO with idle output SHALL give lane 0 on pix_valid in the cycle after edge N (latency 1).
REQ-024 SHALL count a handoff as any edge with pix_valid=1 and pix_ready=1.
REQ-025 SHALL hold pix_r/g/b/x/y/eol/eof and pix_valid stable while pix_valid=1 and pix_ready=0.
REQ-026 SHALL, on a handoff with further data available (next lane or next FIFO quad), present it on the next cycle with no bubble (1 pixel/cycle sustained).
REQ-027 SHALL pop the FIFO head at the handoff of lane 3 and reset the lane counter to 0.
REQ-028 SHALL deassert pix_valid after a handoff when no further data is available; pix_valid SHALL never assert from an empty FIFO.
REQ-029 SHALL assign pix_x/pix_y from internal counters advanced per handoff, independent of input data: x increments, x=H_ACTIVE-1 wraps to 0 and increments y, y=V_ACTIVE-1 wraps to 0.
REQ-030 SHALL drive pix_eol=1 exactly when pix_x=H_ACTIVE-1, and pix_eof=1 exactly when pix_x=H_ACTIVE-1 and pix_y=V_ACTIVE-1.
REQ-031 SHALL keep occupancy in 0..DEPTH; simultaneous push and pop leaves occupancy unchanged, including when full.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force FIFO empty, lane counter 0, pix_x=0, pix_y=0, pix_valid=0, pix_r/g/b=0, pix_eol=0, pix_eof=0, overflow=0.
REQ-033 SHALL discard any in-flight quad or partially serialized quad on reset; first pixel after release is lane 0 of the first quad accepted after release, at (0,0).
REQ-034 SHALL accept no quad on an edge where rst_n=0.

Verification
REQ-035 SHALL test single quad: R=0x11223344,G=0,B=0, pix_ready=1 -> pix_r 0x11,0x22,0x33,0x44 on 4 consecutive cycles, pix_x 0..3, latency 1, then pix_valid=0.
REQ-036 SHALL test backpressure: pix_ready=0 for 5 cycles mid-quad -> outputs frozen, no lane skipped or repeated.
REQ-037 SHALL test overflow: pix_ready=0, valid_in=1 for DEPTH+1 cycles -> in_ready=0 after 4, 5th dropped, overflow=1; clr_ovf pulse -> overflow=0.
REQ-038 SHALL test full push+pop: FIFO full, lane 3 handed off with valid_in=1 -> quad accepted, overflow stays 0, occupancy stays DEPTH.
REQ-039 SHALL test frame wrap: stream 640*480/4 quads -> pix_eol at x=639 each line, pix_eof once at (639,479), next pixel at (0,0).
REQ-040 SHALL test reset mid-quad: rst_n low after lane 1 handoff -> pix_valid=0 immediately; after release new quad starts at lane 0, (0,0).

Source files
------------

// File: rtl/quad_serializer.sv
// Quad-to-pixel serializer: buffers packed RGB quads in a small FIFO and emits
// one registered pixel per handoff with raster X/Y coordinates and EOL/EOF flags.
module quad_serializer #(
  parameter int BITS_X   = 10,
  parameter int BITS_Y   = 9,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [31:0]       R_quad,
  input  logic [31:0]       G_quad,
  input  logic [31:0]       B_quad,
  output logic              in_ready,
  input  logic              clr_ovf,
  output logic              overflow,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic [BITS_X-1:0] pix_x,
  output logic [BITS_Y-1:0] pix_y,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } quad_t;

  quad_t          mem [DEPTH];
  quad_t          in_quad;
  quad_t          src_quad;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     lane, nxt_lane;
  logic           full, handoff, pop, push, drop, load, nxt_valid;
  logic [BITS_X-1:0] nxt_x;
  logic [BITS_Y-1:0] nxt_y;

  // Lane 0 lives in the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] q, input logic [1:0] l);
    case (l)
      2'd0:    return q[31:24];
      2'd1:    return q[23:16];
      2'd2:    return q[15:8];
      default: return q[7:0];
    endcase
  endfunction

  assign in_quad  = '{r: R_quad, g: G_quad, b: B_quad};
  assign full     = (count == CW'(DEPTH));
  assign in_ready = ~full;
  assign handoff  = pix_valid & pix_ready;
  assign pop      = handoff & (lane == 2'd3);
  assign push     = valid_in & (~full | pop);
  assign drop     = valid_in & ~push;
  assign load     = ~pix_valid | handoff;

  // The head quad stays in the FIFO while it is serialized; once it retires,
  // the next pixel comes from the following entry or, if none, straight from
  // the quad arriving on this edge so an idle output fills with latency 1.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    nxt_valid = pix_valid;
    nxt_lane  = lane;
    src_quad  = mem[rd_ptr];
    if (handoff && lane != 2'd3) begin
      nxt_valid = 1'b1;
      nxt_lane  = lane + 2'd1;
    end else if (!pix_valid || pop) begin
      nxt_lane = 2'd0;
      if (count > CW'(pop)) begin
        src_quad  = mem[rd_ptr + PW'(pop)];
        nxt_valid = 1'b1;
      end else if (push) begin
        src_quad  = in_quad;
        nxt_valid = 1'b1;
      end else begin
        nxt_valid = 1'b0;
      end
    end
  end

  always_comb begin
    nxt_x = pix_x;
    nxt_y = pix_y;
    if (handoff) begin
      if (pix_x == BITS_X'(H_ACTIVE - 1)) begin
        nxt_x = '0;
        nxt_y = (pix_y == BITS_Y'(V_ACTIVE - 1)) ? '0 : pix_y + 1'b1;
      end else begin
        nxt_x = pix_x + 1'b1;
      end
    end
  end

  // NOTE: the quad storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_quad;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      lane      <= 2'd0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else if (load) begin
      pix_valid <= nxt_valid;
      lane      <= nxt_lane;
      if (nxt_valid) begin
        pix_r <= lane_byte(src_quad.r, nxt_lane);
        pix_g <= lane_byte(src_quad.g, nxt_lane);
        pix_b <= lane_byte(src_quad.b, nxt_lane);
      end
    end
  end

  // Coordinates advance on every handoff regardless of pixel content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x   <= '0;
      pix_y   <= '0;
      pix_eol <= 1'b0;
      pix_eof <= 1'b0;
    end else begin
      pix_x   <= nxt_x;
      pix_y   <= nxt_y;
      pix_eol <= (nxt_x == BITS_X'(H_ACTIVE - 1));
      pix_eof <= (nxt_x == BITS_X'(H_ACTIVE - 1)) && (nxt_y == BITS_Y'(V_ACTIVE - 1));
    end
  end

endmodule
